hazard_controller: RTL

Pipeline hazard sequencer for the five-stage ARM core. Detects load-use hazards between the ID and EX stages, stalls PC and IF/ID, and drives the control-unit NOP-mux select to inject bubbles into ID/EX. Freezes the whole pipeline while the data memory has not acknowledged an access, and flushes IF/ID on taken branches. Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_if.sv | 33 +++
 rtl/hazard_controller.sv | 131 +++++++++++++
 2 files changed

// File: rtl/hazard_if.sv
// Hazard-sequencer signal bundle: ID/EX register info, branch and data-memory
// status in, pipeline enable/flush/bubble/freeze controls out.
interface hazard_if;
  logic [3:0] id_rn;
  logic [3:0] id_rm;
  logic [3:0] id_rs;
  logic       id_rn_used;
  logic       id_rm_used;
  logic       id_rs_used;
  logic [3:0] ex_rd;
  logic       ex_reg_write;
  logic       ex_mem_read;
  logic       branch_taken;
  logic       mem_req;
  logic       mem_ack;
  logic       pc_enable;
  logic       if_id_enable;
  logic       if_id_flush;
  logic       cu_nop_select;
  logic       pipe_freeze;

  modport master (
    output id_rn, id_rm, id_rs, id_rn_used, id_rm_used, id_rs_used,
    output ex_rd, ex_reg_write, ex_mem_read, branch_taken, mem_req, mem_ack,
    input  pc_enable, if_id_enable, if_id_flush, cu_nop_select, pipe_freeze
  );

  modport slave (
    input  id_rn, id_rm, id_rs, id_rn_used, id_rm_used, id_rs_used,
    input  ex_rd, ex_reg_write, ex_mem_read, branch_taken, mem_req, mem_ack,
    output pc_enable, if_id_enable, if_id_flush, cu_nop_select, pipe_freeze
  );
endinterface

// File: rtl/hazard_controller.sv
// Load-use / memory-wait hazard sequencer for the five-stage core; all control
// outputs are combinational, only state, bubble count and stall counter are flops.
//
// state    | meaning
// RUN      | normal flow; detects load-use hazards, memory stalls and taken branches
// LU_STALL | remaining load-use bubbles are being inserted (bub_q left after this one)
// MEM_WAIT | pipeline frozen until data memory acknowledges
module hazard_controller #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_if.slave          hz,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_e;

  localparam logic [2:0] BUB_INIT = 3'(LOAD_STALL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       bub_q, bub_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic hazard, mem_stall, run_rules;
  logic pc_en, ifid_en, flush, nop_sel, freeze;

  assign hazard = hz.ex_mem_read & hz.ex_reg_write &
                  ((hz.id_rn_used & (hz.id_rn == hz.ex_rd)) |
                   (hz.id_rm_used & (hz.id_rm == hz.ex_rd)) |
                   (hz.id_rs_used & (hz.id_rs == hz.ex_rd)));
  assign mem_stall = hz.mem_req & ~hz.mem_ack;

  always_comb begin
    state_d   = state_q;
    bub_d     = bub_q;
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    flush     = 1'b0;
    nop_sel   = 1'b0;
    freeze    = 1'b0;
    run_rules = 1'b0;

    case (state_q)
      RUN: run_rules = 1'b1;
      LU_STALL: begin
        if (mem_stall) begin
          freeze  = 1'b1;
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          state_d = MEM_WAIT;
        end else begin
          nop_sel = 1'b1;
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          bub_d   = bub_q - 3'd1;
          if (bub_q == 3'd1) state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (!hz.mem_ack) begin
          freeze  = 1'b1;
          pc_en   = 1'b0;
          ifid_en = 1'b0;
        end else if (bub_q != 3'd0) begin
          // ack cycle consumes one of the bubbles still owed
          nop_sel = 1'b1;
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          bub_d   = bub_q - 3'd1;
          state_d = (bub_q == 3'd1) ? RUN : LU_STALL;
        end else begin
          state_d   = RUN;
          run_rules = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if (run_rules) begin
      if (mem_stall) begin
        freeze  = 1'b1;
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        state_d = MEM_WAIT;
      end else if (hazard) begin
        nop_sel = 1'b1;
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        if (LOAD_STALL_CYCLES > 1) begin
          bub_d   = BUB_INIT;
          state_d = LU_STALL;
        end
      end else if (hz.branch_taken) begin
        flush = 1'b1;
      end
    end

    if (!rst_n) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      flush   = 1'b0;
      nop_sel = 1'b1;
      freeze  = 1'b0;
    end

    cnt_d = cnt_q;
    if ((nop_sel | freeze) && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      bub_q   <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.pc_enable     = pc_en;
  assign hz.if_id_enable  = ifid_en;
  assign hz.if_id_flush   = flush;
  assign hz.cu_nop_select = nop_sel;
  assign hz.pipe_freeze   = freeze;
  assign stall_cycles     = cnt_q;

endmodule
